// File: rtl/vit_ctrl_seq.sv
// Sequencing controller for the Viterbi decoder datapath.
// Walks one frame of FRAME_LEN symbols through the pipeline fill phases
// (branch metric, then ACS, then full run with survivor memory), then runs
// TB_DEPTH traceback cycles and signals completion with a one-cycle done.
// Symbol phases stall on sym_valid=0; traceback runs unconditionally.
// abort returns to IDLE from anywhere; cont chains frames without IDLE.
module vit_ctrl_seq #(
    parameter int FRAME_LEN = 16,
    parameter int TB_DEPTH  = 8,
    localparam int CW = $clog2(((FRAME_LEN > TB_DEPTH) ? FRAME_LEN : TB_DEPTH) + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          cont,
    input  logic          sym_valid,
    input  logic          abort,
    output logic          en_brch,
    output logic          en_add,
    output logic          en_mem,
    output logic          en_tbck,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] sym_cnt,
    output logic [CW-1:0] tb_cnt
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FILL_BM  = 3'd1;
    localparam logic [2:0] FILL_ACS = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] TBCK     = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    // Last symbol index of the frame and last traceback index.
    localparam logic [CW-1:0] SYM_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] TB_LAST  = CW'(TB_DEPTH - 1);

    logic [2:0]    state_reg;
    logic [2:0]    state_next;
    logic [CW-1:0] sym_reg;
    logic [CW-1:0] sym_next;
    logic [CW-1:0] tb_reg;
    logic [CW-1:0] tb_next;

    // State and counter registers; reset drops any frame in flight at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            sym_reg   <= '0;
            tb_reg    <= '0;
        end else begin
            state_reg <= state_next;
            sym_reg   <= sym_next;
            tb_reg    <= tb_next;
        end
    end

    // Next-state and counter update; abort overrides everything else.
    always_comb begin
        state_next = state_reg;
        sym_next   = sym_reg;
        tb_next    = tb_reg;
        if (abort) begin
            state_next = IDLE;
            sym_next   = '0;
            tb_next    = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next = FILL_BM;
                        sym_next   = '0;
                        tb_next    = '0;
                    end
                end
                FILL_BM: begin
                    // FRAME_LEN >= 3, so the first two symbols never end the frame.
                    if (sym_valid) begin
                        sym_next   = sym_reg + 1'b1;
                        state_next = FILL_ACS;
                    end
                end
                FILL_ACS: begin
                    if (sym_valid) begin
                        sym_next   = sym_reg + 1'b1;
                        state_next = RUN;
                    end
                end
                RUN: begin
                    if (sym_valid) begin
                        // The final increment leaves sym_cnt at FRAME_LEN for the
                        // rest of the frame.
                        sym_next = sym_reg + 1'b1;
                        if (sym_reg == SYM_LAST) begin
                            state_next = TBCK;
                        end
                    end
                end
                TBCK: begin
                    // tb_cnt stops at its last index rather than wrapping.
                    if (tb_reg == TB_LAST) begin
                        state_next = DONE;
                    end else begin
                        tb_next = tb_reg + 1'b1;
                    end
                end
                DONE: begin
                    if (start || cont) begin
                        state_next = FILL_BM;
                        sym_next   = '0;
                        tb_next    = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    sym_next   = '0;
                    tb_next    = '0;
                end
            endcase
        end
    end

    // Moore-style output decode; symbol-phase enables are gated by sym_valid
    // so a stalled cycle issues no datapath work.
    always_comb begin
        en_brch = 1'b0;
        en_add  = 1'b0;
        en_mem  = 1'b0;
        en_tbck = 1'b0;
        done    = 1'b0;
        busy    = (state_reg != IDLE);
        case (state_reg)
            FILL_BM: begin
                en_brch = sym_valid;
            end
            FILL_ACS: begin
                en_brch = sym_valid;
                en_add  = sym_valid;
            end
            RUN: begin
                en_brch = sym_valid;
                en_add  = sym_valid;
                en_mem  = sym_valid;
            end
            TBCK: begin
                en_mem  = 1'b1;
                en_tbck = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                en_brch = 1'b0;
            end
        endcase
    end

    assign sym_cnt = sym_reg;
    assign tb_cnt  = tb_reg;

endmodule

// File: tb/tb_vit_ctrl_seq.sv
// Self-checking bench for vit_ctrl_seq: a 16/8 instance and a 3/1 instance
// share the stimulus; each test selects which one it observes.
// Cycle k is the clock period that ends with edge k; start is high in cycle 0.
module tb_vit_ctrl_seq;

    typedef struct {
        int         cyc;
        logic [3:0] en;    // {brch, add, mem, tbck}
        logic       busy;
        logic       done;
        int         sym;   // -1: not checked
        int         tb;    // -1: not checked
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic cont = 1'b0;
    logic sym_valid = 1'b0;
    logic abort = 1'b0;

    logic       b1, a1, m1, t1, busy1, done1;
    logic [4:0] s1, tb1;
    logic       b2, a2, m2, t2, busy2, done2;
    logic [1:0] s2, tb2;

    logic        sel = 1'b0;
    logic [3:0]  m_en;
    logic        m_busy, m_done;
    logic [31:0] m_sym, m_tb;

    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic hold_start = 1'b0;
    logic cont_v = 1'b0;
    int   stall_lo = -10;
    int   stall_hi = -10;
    int   abort_cyc = -1;
    int   done_cycs[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    vit_ctrl_seq #(.FRAME_LEN(16), .TB_DEPTH(8)) dut_big (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .sym_valid(sym_valid), .abort(abort),
        .en_brch(b1), .en_add(a1), .en_mem(m1), .en_tbck(t1),
        .busy(busy1), .done(done1), .sym_cnt(s1), .tb_cnt(tb1)
    );

    vit_ctrl_seq #(.FRAME_LEN(3), .TB_DEPTH(1)) dut_small (
        .clk(clk), .rst(rst), .start(start), .cont(cont),
        .sym_valid(sym_valid), .abort(abort),
        .en_brch(b2), .en_add(a2), .en_mem(m2), .en_tbck(t2),
        .busy(busy2), .done(done2), .sym_cnt(s2), .tb_cnt(tb2)
    );

    assign m_en   = sel ? {b2, a2, m2, t2} : {b1, a1, m1, t1};
    assign m_busy = sel ? busy2 : busy1;
    assign m_done = sel ? done2 : done1;
    assign m_sym  = sel ? 32'(s2) : 32'(s1);
    assign m_tb   = sel ? 32'(tb2) : 32'(tb1);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    endtask

    task automatic check_vec(input vec_t v);
        $display("vec cyc=%0d en=%b busy=%b done=%b sym=%0d tb=%0d",
                 v.cyc, m_en, m_busy, m_done, m_sym, m_tb);
        chk("en", 32'(m_en), 32'(v.en));
        chk("busy", 32'(m_busy), 32'(v.busy));
        chk("done", 32'(m_done), 32'(v.done));
        if (v.sym >= 0) chk("sym_cnt", m_sym, v.sym);
        if (v.tb >= 0) chk("tb_cnt", m_tb, v.tb);
    endtask

    task automatic check_idle(input string name);
        chk({name, "_en"}, 32'(m_en), 32'd0);
        chk({name, "_busy"}, 32'(m_busy), 32'd0);
        chk({name, "_done"}, 32'(m_done), 32'd0);
    endtask

    task automatic do_reset();
        start = 1'b0; cont = 1'b0; abort = 1'b0; sym_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #2;
        hold_start = 1'b0; cont_v = 1'b0;
        stall_lo = -10; stall_hi = -10; abort_cyc = -1;
        vecs.delete();
        done_cycs.delete();
    endtask

    // Raise start in the current (idle) cycle so it is sampled at edge 0.
    task automatic begin_frame();
        start = 1'b1; sym_valid = 1'b1; abort = 1'b0; cont = cont_v;
        cyc = 0;
    endtask

    // Run cycles 1..last, driving per-cycle inputs, then checking the table
    // entries for that cycle and the expected done pattern.
    task automatic run_seq(input int last);
        logic dexp;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            cyc = c;
            #1;
            start     = hold_start;
            cont      = cont_v;
            sym_valid = !(c >= stall_lo && c <= stall_hi);
            abort     = (c == abort_cyc);
            #1;
            foreach (vecs[i]) if (vecs[i].cyc == c) check_vec(vecs[i]);
            dexp = 1'b0;
            foreach (done_cycs[k]) if (done_cycs[k] == c) dexp = 1'b1;
            chk("done_sweep", 32'(m_done), 32'(dexp));
        end
    endtask

    initial begin
        // Reset state, observed while rst is still asserted.
        #1 rst = 1'b1;
        #2;
        sel = 1'b0;
        check_idle("rst_big");
        chk("rst_big_sym", m_sym, 0);
        chk("rst_big_tb", m_tb, 0);
        sel = 1'b1;
        check_idle("rst_small");

        // Basic frame, no stalls.
        sel = 1'b0;
        do_reset();
        vecs.push_back('{1,  4'b1000, 1'b1, 1'b0, 0,  0});
        vecs.push_back('{2,  4'b1100, 1'b1, 1'b0, 1,  0});
        vecs.push_back('{3,  4'b1110, 1'b1, 1'b0, 2,  0});
        vecs.push_back('{10, 4'b1110, 1'b1, 1'b0, 9,  0});
        vecs.push_back('{16, 4'b1110, 1'b1, 1'b0, 15, 0});
        vecs.push_back('{17, 4'b0011, 1'b1, 1'b0, 16, 0});
        vecs.push_back('{24, 4'b0011, 1'b1, 1'b0, 16, 7});
        vecs.push_back('{25, 4'b0000, 1'b1, 1'b1, 16, 7});
        vecs.push_back('{26, 4'b0000, 1'b0, 1'b0, -1, -1});
        done_cycs.push_back(25);
        begin_frame();
        run_seq(27);

        // Three stall cycles inside RUN push done to cycle 28.
        do_reset();
        stall_lo = 5; stall_hi = 7;
        vecs.push_back('{4,  4'b1110, 1'b1, 1'b0, 3,  0});
        vecs.push_back('{5,  4'b0000, 1'b1, 1'b0, 4,  0});
        vecs.push_back('{7,  4'b0000, 1'b1, 1'b0, 4,  0});
        vecs.push_back('{8,  4'b1110, 1'b1, 1'b0, 4,  0});
        vecs.push_back('{19, 4'b1110, 1'b1, 1'b0, 15, 0});
        vecs.push_back('{20, 4'b0011, 1'b1, 1'b0, 16, 0});
        vecs.push_back('{27, 4'b0011, 1'b1, 1'b0, 16, 7});
        vecs.push_back('{28, 4'b0000, 1'b1, 1'b1, 16, 7});
        vecs.push_back('{29, 4'b0000, 1'b0, 1'b0, -1, -1});
        done_cycs.push_back(28);
        begin_frame();
        run_seq(29);

        // Continuous framing: DONE goes straight to FILL_BM.
        do_reset();
        cont_v = 1'b1;
        vecs.push_back('{25, 4'b0000, 1'b1, 1'b1, 16, 7});
        vecs.push_back('{26, 4'b1000, 1'b1, 1'b0, 0,  0});
        vecs.push_back('{27, 4'b1100, 1'b1, 1'b0, 1,  0});
        vecs.push_back('{42, 4'b0011, 1'b1, 1'b0, 16, 0});
        vecs.push_back('{50, 4'b0000, 1'b1, 1'b1, 16, 7});
        vecs.push_back('{51, 4'b1000, 1'b1, 1'b0, 0,  0});
        done_cycs.push_back(25);
        done_cycs.push_back(50);
        begin_frame();
        run_seq(51);

        // Abort during traceback, then a normal restart.
        do_reset();
        abort_cyc = 20;
        vecs.push_back('{20, 4'b0011, 1'b1, 1'b0, 16, 3});
        vecs.push_back('{21, 4'b0000, 1'b0, 1'b0, 0,  0});
        vecs.push_back('{25, 4'b0000, 1'b0, 1'b0, 0,  0});
        begin_frame();
        run_seq(30);
        abort_cyc = -1;
        vecs.delete();
        vecs.push_back('{1, 4'b1000, 1'b1, 1'b0, 0, 0});
        vecs.push_back('{2, 4'b1100, 1'b1, 1'b0, 1, 0});
        begin_frame();
        run_seq(2);

        // Asynchronous reset mid-RUN.
        do_reset();
        vecs.push_back('{8, 4'b1110, 1'b1, 1'b0, 7, 0});
        begin_frame();
        run_seq(8);
        #1 rst = 1'b1;
        #1;
        check_idle("async_rst");
        chk("async_rst_sym", m_sym, 0);
        chk("async_rst_tb", m_tb, 0);
        #2 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #2;
            check_idle("post_rst");
        end
        vecs.delete();
        vecs.push_back('{1, 4'b1000, 1'b1, 1'b0, 0, 0});
        begin_frame();
        run_seq(1);

        // abort together with start in IDLE keeps the controller idle.
        do_reset();
        start = 1'b1; abort = 1'b1; sym_valid = 1'b1;
        @(posedge clk);
        #2;
        check_idle("abort_start");
        start = 1'b0; abort = 1'b0;
        @(posedge clk);
        #2;
        check_idle("abort_start2");

        // Minimum frame, start held high throughout.
        sel = 1'b1;
        do_reset();
        hold_start = 1'b1;
        vecs.push_back('{1, 4'b1000, 1'b1, 1'b0, 0, 0});
        vecs.push_back('{2, 4'b1100, 1'b1, 1'b0, 1, 0});
        vecs.push_back('{3, 4'b1110, 1'b1, 1'b0, 2, 0});
        vecs.push_back('{4, 4'b0011, 1'b1, 1'b0, 3, 0});
        vecs.push_back('{5, 4'b0000, 1'b1, 1'b1, 3, 0});
        vecs.push_back('{6, 4'b1000, 1'b1, 1'b0, 0, 0});
        done_cycs.push_back(5);
        begin_frame();
        run_seq(6);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vit_ctrl_seq.md
# vit_ctrl_seq

Parametrised sequencing controller for the Viterbi decoder datapath. Drives the branch-metric, add-compare-select, survivor-memory and traceback enables over one frame of FRAME_LEN received symbols followed by TB_DEPTH traceback cycles. Adds a start/done/busy handshake, per-symbol stall via sym_valid, synchronous abort, and back-to-back continuous framing.

## Interface
- FRAME_LEN, 16: symbols per frame; legal range ≥ 3.
- TB_DEPTH, 8: traceback cycles per frame; legal range ≥ 1.
- CW (localparam): $clog2(max(FRAME_LEN, TB_DEPTH) + 1), the counter width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a frame; sampled in IDLE and DONE.
- cont  in  1  continuous mode; sampled in DONE.
- sym_valid  in  1  a new symbol is present this cycle; low stalls the symbol phases.
- abort  in  1  synchronous abort to IDLE; has priority over every other input.
- en_brch  out  1  branch-metric / hamming-distance enable.
- en_add  out  1  ACS enable.
- en_mem  out  1  survivor-memory write/read enable.
- en_tbck  out  1  traceback enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a frame.
- sym_cnt  out  CW  number of accepted symbols in the current frame.
- tb_cnt  out  CW  traceback cycle index.

## Operation
- States: IDLE, FILL_BM, FILL_ACS, RUN, TBCK, DONE.
- Outputs are Moore-decoded from the state, with no extra register stage.
- Per-state outputs, listed as brch/add/mem/tbck:
  - IDLE: 0/0/0/0.
  - FILL_BM: v/0/0/0.
  - FILL_ACS: v/v/0/0.
  - RUN: v/v/v/0.
  - TBCK: 0/0/1/1.
  - DONE: 0/0/0/0, with done=1.
  - Here v = sym_valid.
- Accepted symbol: a cycle in FILL_BM, FILL_ACS or RUN with sym_valid=1.
  - Each accepted symbol increments sym_cnt.
  - When sym_valid=0, state and counters hold and en_brch/en_add/en_mem are 0.
- Transitions:
  - IDLE → FILL_BM on start. sym_cnt and tb_cnt clear to 0.
  - FILL_BM → FILL_ACS on an accepted symbol.
  - FILL_ACS → RUN on an accepted symbol.
  - RUN → TBCK on the accepted symbol that has sym_cnt == FRAME_LEN-1. sym_cnt then holds at FRAME_LEN.
  - TBCK cannot be stalled. tb_cnt increments every cycle. TBCK → DONE when tb_cnt == TB_DEPTH-1.
  - DONE → FILL_BM if start or cont; counters clear to 0. Otherwise DONE → IDLE.
- abort=1 in any state: next state IDLE and counters cleared. No done pulse.
- start while busy (outside DONE) is ignored.
- Counters never wrap: sym_cnt ≤ FRAME_LEN and tb_cnt ≤ TB_DEPTH-1.

## Timing
- On rst, asynchronously:
  - state = IDLE and sym_cnt = tb_cnt = 0.
  - All en_* = 0, busy = 0, done = 0.
  - Reset mid-frame drops the frame immediately, with no done pulse.
- Start latency: with start high at edge N, FILL_BM is active in the cycle after edge N, and en_brch=1 if sym_valid.
- Frame length with no stalls: FRAME_LEN symbol cycles + TB_DEPTH traceback cycles + 1 DONE cycle.
  - Each stall cycle in the symbol phase adds one cycle.
- Continuous mode gives one idle-enable (DONE) cycle between frames and no IDLE cycle.
- abort asserted together with start in IDLE: stay in IDLE.

## Test plan
- FRAME_LEN=16, TB_DEPTH=8, sym_valid=1, start pulse sampled at edge 0 → expected response:
  - en_brch rises in cycle 1.
  - en_add in cycle 2 and en_mem in cycle 3.
  - en_tbck in cycles 17–24.
  - done=1 only in cycle 25.
  - busy=0 in cycle 26.
- Same frame with sym_valid=0 for 3 cycles inside RUN → en_brch/en_add/en_mem are 0 during the gap, sym_cnt holds, and done moves to cycle 28.
- cont=1 held → FILL_BM follows DONE directly (cycle 26), sym_cnt restarts at 0, and done pulses every 25 cycles.
- abort at cycle 20 (TBCK) → IDLE in cycle 21, all outputs 0, counters 0, and done never asserts; a new start is then accepted normally.
- rst asserted asynchronously mid-RUN (cycle 8) → all outputs 0 before the next edge; after release, the state stays IDLE until start.
- FRAME_LEN=3, TB_DEPTH=1 → en_tbck in cycle 4 only and done in cycle 5; start held high during busy causes no restart until DONE.
